// File: rtl/window_data_buffer.sv
// ============================================================================
// Module   : window_data_buffer
// Purpose  : Collects signed samples into an 8-deep sliding window and emits
//            it packed, with stride control, for the window-sum stage.
//            Optional macro WINDOW_SEQ_CNT_EN adds a window sequence counter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module window_data_buffer #(
  parameter int SAMPLE_W = 32,
  parameter int WIN_LEN  = 8,
  parameter int STRIDE   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic [SAMPLE_W-1:0]          in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [SAMPLE_W*WIN_LEN-1:0]  windowdata,
  output logic                         window_valid,
  input  logic                         window_ready
`ifdef WINDOW_SEQ_CNT_EN
  ,
  output logic [15:0]                  win_seq
`endif
);

  localparam int c_WIN_W    = SAMPLE_W * WIN_LEN;
  localparam int c_FILL_W   = $clog2(WIN_LEN + 1);
  localparam int c_STRIDE_W = $clog2(STRIDE + 1);
  localparam logic [c_FILL_W-1:0]   c_FILL_MAX   = c_FILL_W'(WIN_LEN);
  localparam logic [c_STRIDE_W-1:0] c_STRIDE_MAX = c_STRIDE_W'(STRIDE);

  logic [c_WIN_W-1:0]    r_windowdata;
  logic                  r_window_valid;
  logic [c_FILL_W-1:0]   r_fill;
  logic [c_STRIDE_W-1:0] r_stride;

  logic                  w_accept;
  logic                  w_first_fill;
  logic                  w_emit;
  logic [c_FILL_W-1:0]   w_fill_next;
  logic [c_STRIDE_W-1:0] w_stride_next;

  assign in_ready     = !clear && (!r_window_valid || window_ready);
  assign w_accept     = in_valid && in_ready;

  // Both counters saturate; stride is only meaningful once the window is full,
  // and it is cleared on every emission so it never exceeds STRIDE afterwards.
  assign w_fill_next   = (r_fill == c_FILL_MAX) ? r_fill : r_fill + c_FILL_W'(1);
  assign w_stride_next = (r_stride == c_STRIDE_MAX) ? r_stride
                                                    : r_stride + c_STRIDE_W'(1);
  assign w_first_fill  = (r_fill != c_FILL_MAX);
  assign w_emit        = w_accept && (w_fill_next == c_FILL_MAX) &&
                         (w_first_fill || (w_stride_next == c_STRIDE_MAX));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_windowdata   <= '0;
      r_window_valid <= 1'b0;
      r_fill         <= '0;
      r_stride       <= '0;
    end else begin
      if (w_accept) begin
        // Slot 0 (LSBs) is oldest; the new sample enters at the top slot.
        r_windowdata <= {in_data, r_windowdata[c_WIN_W-1:SAMPLE_W]};
        r_fill       <= w_fill_next;
        r_stride     <= w_emit ? '0 : w_stride_next;
      end
      if (w_emit) begin
        r_window_valid <= 1'b1;
      end else if (r_window_valid && window_ready) begin
        r_window_valid <= 1'b0;
      end
    end
  end

`ifdef WINDOW_SEQ_CNT_EN
  logic [15:0] r_win_seq;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_win_seq <= '0;
    end else if (r_window_valid && window_ready) begin
      r_win_seq <= r_win_seq + 16'd1;
    end
  end

  assign win_seq = r_win_seq;
`endif

  assign windowdata   = r_windowdata;
  assign window_valid = r_window_valid;

endmodule

`default_nettype wire
